// File: rtl/cnn_conv_engine.sv
// Stride-1 valid 2D convolution engine for a single-port memory.
// Loads the kernel, then does one read and one MAC per tap, then writes each output.
module cnn_conv_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] from_memory,
    output logic              read_en,
    output logic              write_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              busy,
    output logic              done,
    output logic [15:0]       out_count
);

    localparam int OW  = IMG_W-K+1;
    localparam int OH  = IMG_H-K+1;
    localparam int KK  = K*K;
    localparam int KIW = (KK > 1) ? $clog2(KK) : 1;
    localparam int CW  = 16;

    localparam logic [KIW-1:0] KI_LAST = KIW'(KK-1);
    localparam logic [CW-1:0]  K_LAST  = CW'(K-1);
    localparam logic [CW-1:0]  OX_LAST = CW'(OW-1);
    localparam logic [CW-1:0]  OY_LAST = CW'(OH-1);

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, LOAD_K, RD_PIX, MAC, WRITE, DONE
    } state_t;

    state_t                    st;
    logic [ADDR_W-1:0]         img_b;
    logic [ADDR_W-1:0]         ker_b;
    logic [ADDR_W-1:0]         out_b;
    logic [4:0]                shift_r;
    logic                      relu_r;
    logic [KIW-1:0]            kidx;
    logic [CW-1:0]             kx;
    logic [CW-1:0]             ky;
    logic [CW-1:0]             ox;
    logic [CW-1:0]             oy;
    logic signed [DATA_W-1:0]  w [KK];
    logic signed [DATA_W-1:0]  pix;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [DATA_W-1:0]         res;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] b,
        input int r,
        input int c
    );
        return b + ADDR_W'(r*IMG_W + c);
    endfunction

    // Shift, then ReLU, then saturate to the output word.
    function automatic logic [DATA_W-1:0] form(
        input logic signed [ACC_W-1:0] a,
        input logic [4:0]              s,
        input logic                    r
    );
        logic signed [ACC_W-1:0] v;
        v = a >>> s;
        if (r && v[ACC_W-1]) v = '0;
        if (v > MAXV) return {1'b0, {(DATA_W-1){1'b1}}};
        if (v < MINV) return {1'b1, {(DATA_W-1){1'b0}}};
        return v[DATA_W-1:0];
    endfunction

    always_comb begin
        prod    = w[kidx] * pix;
        acc_sum = acc + ACC_W'(prod);
        res     = form(acc_sum, shift_r, relu_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_en   <= 1'b0;
            write_en  <= 1'b0;
            address   <= '0;
            to_memory <= '0;
            out_count <= '0;
            acc       <= '0;
            pix       <= '0;
            kidx      <= '0;
            kx        <= '0;
            ky        <= '0;
            ox        <= '0;
            oy        <= '0;
            img_b     <= '0;
            ker_b     <= '0;
            out_b     <= '0;
            shift_r   <= '0;
            relu_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                IDLE: if (start) begin
                    img_b     <= img_base;
                    ker_b     <= ker_base;
                    out_b     <= out_base;
                    shift_r   <= shift;
                    relu_r    <= relu_en;
                    out_count <= '0;
                    acc       <= '0;
                    kidx      <= '0;
                    kx        <= '0;
                    ky        <= '0;
                    ox        <= '0;
                    oy        <= '0;
                    busy      <= 1'b1;
                    read_en   <= 1'b1;
                    address   <= ker_base;
                    st        <= LOAD_K;
                end
                LOAD_K: if (mem_ready) begin
                    w[kidx] <= from_memory;
                    if (kidx == KI_LAST) begin
                        kidx    <= '0;
                        address <= pix_addr(img_b, 0, 0);
                        st      <= RD_PIX;
                    end else begin
                        kidx    <= kidx + KIW'(1);
                        address <= ker_b + ADDR_W'(kidx) + ADDR_W'(1);
                    end
                end
                RD_PIX: if (mem_ready) begin
                    pix     <= from_memory;
                    read_en <= 1'b0;
                    st      <= MAC;
                end
                MAC: begin
                    acc <= acc_sum;
                    if (kidx == KI_LAST) begin
                        write_en  <= 1'b1;
                        address   <= out_b +
                            ADDR_W'(int'(oy)*OW + int'(ox));
                        to_memory <= res;
                        st        <= WRITE;
                    end else begin
                        kidx    <= kidx + KIW'(1);
                        read_en <= 1'b1;
                        st      <= RD_PIX;
                        if (kx == K_LAST) begin
                            kx      <= '0;
                            ky      <= ky + CW'(1);
                            address <= pix_addr(img_b,
                                int'(oy) + int'(ky) + 1, int'(ox));
                        end else begin
                            kx      <= kx + CW'(1);
                            address <= pix_addr(img_b,
                                int'(oy) + int'(ky),
                                int'(ox) + int'(kx) + 1);
                        end
                    end
                end
                WRITE: if (mem_ready) begin
                    write_en  <= 1'b0;
                    out_count <= out_count + 16'd1;
                    acc       <= '0;
                    kidx      <= '0;
                    kx        <= '0;
                    ky        <= '0;
                    if (ox == OX_LAST && oy == OY_LAST) begin
                        st <= DONE;
                    end else begin
                        read_en <= 1'b1;
                        st      <= RD_PIX;
                        if (ox == OX_LAST) begin
                            ox      <= '0;
                            oy      <= oy + CW'(1);
                            address <= pix_addr(img_b, int'(oy) + 1, 0);
                        end else begin
                            ox      <= ox + CW'(1);
                            address <= pix_addr(img_b, int'(oy),
                                int'(ox) + 1);
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cnn_conv_engine.md
CNN_CONV_ENGINE -- requirements
Module: cnn_conv_engine

Parameters
REQ-001 SHALL have parameter DATA_W, default 16, pixel/weight/output word width (signed two's complement).
REQ-002 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-003 SHALL have parameter IMG_W, default 8, input image width in words.
REQ-004 SHALL have parameter IMG_H, default 8, input image height in words.
REQ-005 SHALL have parameter K, default 3, square kernel size; K <= IMG_W and K <= IMG_H.
REQ-006 SHALL have parameter ACC_W, default 2*DATA_W+8, signed accumulator width.

Interface
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1, begin one full convolution pass.
REQ-010 SHALL have ports img_base, ker_base and out_base, input, ADDR_W each, base addresses of image, kernel and output.
REQ-011 SHALL have port shift, input, 5, arithmetic right-shift amount applied to the accumulator.
REQ-012 SHALL have port relu_en, input, 1, clamp negative results to 0.
REQ-013 SHALL have port mem_ready, input, 1, completes the current memory transaction.
REQ-014 SHALL have port from_memory, input, DATA_W, read data, valid when read_en and mem_ready are both 1.
REQ-015 SHALL have port read_en, output, 1, read request.
REQ-016 SHALL have port write_en, output, 1, write request.
REQ-017 SHALL have port address, output, ADDR_W, memory address.
REQ-018 SHALL have port to_memory, output, DATA_W, write data.
REQ-019 SHALL have ports busy and done, output, 1 each: pass in progress, and a 1-cycle completion pulse.
REQ-020 SHALL have port out_count, output, 16, outputs written in the current or last pass.

Function
REQ-021 SHALL compute a valid, stride-1 2D convolution: OW=IMG_W-K+1, OH=IMG_H-K+1, out[oy][ox]=sum over ky,kx of w[ky*K+kx]*img[(oy+ky)*IMG_W+ox+kx].
REQ-022 SHALL use FSM states IDLE, LOAD_K, RD_PIX, MAC, WRITE, DONE.
REQ-023 In IDLE, start=1 SHALL latch all bases, shift and relu_en, clear out_count, and go to LOAD_K; input changes during a pass SHALL have no effect.
REQ-024 LOAD_K SHALL read K*K weights from ker_base+i, i=0..K*K-1, into internal registers, one per completed transaction, then go to RD_PIX.
REQ-025 A transaction SHALL complete in any cycle where (read_en|write_en)&mem_ready=1; otherwise address, to_memory and strobe SHALL be held unchanged (wait state).
REQ-026 read_en and write_en SHALL never be 1 together; both SHALL be 0 in IDLE, MAC and DONE.
REQ-027 RD_PIX SHALL read the tap pixel and capture it on completion; MAC (exactly 1 cycle) SHALL add the signed full-precision product to the accumulator.
REQ-028 After the last tap of an output, the FSM SHALL go to WRITE; otherwise it SHALL return to RD_PIX for the next tap, in kx-fastest then ky order.
REQ-029 Result formation, in order: arithmetic shift of acc right by shift; if relu_en and negative then 0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 WRITE SHALL drive address=out_base+oy*OW+ox and to_memory=result; on completion it SHALL increment out_count, clear the accumulator, and advance ox-fastest.
REQ-031 After the write of the last output, the FSM SHALL go to DONE: done=1 for one cycle, then IDLE.
REQ-032 All address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 start in any state other than IDLE SHALL be ignored.
REQ-035 With mem_ready held at 1, done SHALL rise exactly K*K + OH*OW*(2*K*K+1) + 1 clock edges after the edge that samples start.

Reset
REQ-036 rst=1 at a rising edge SHALL force IDLE and set busy=0, done=0, read_en=0, write_en=0, address=0, to_memory=0, out_count=0, and clear the accumulator and all counters, including when a pass is in progress.
REQ-037 After reset, the kernel registers need not be cleared, but no stale weight SHALL be used: every pass reloads them.

Verification
REQ-038 IMG 4x4, K=3, all pixels 1, all weights 1, shift 0, mem_ready=1 -> four writes of 0x0009 at out_base..out_base+3; done 86 edges after start; out_count=4.
REQ-039 Same setup with weights 0xFFFF: relu_en=0 -> outputs 0xFFF7; relu_en=1 -> outputs 0x0000; with shift=1 and relu_en=0 -> outputs 0xFFFB.
REQ-040 Pixels 0x7FFF and weights 0x7FFF -> outputs 0x7FFF; pixels 0x8000 and weights 0x7FFF -> outputs 0x8000 (saturation at both ends).
REQ-041 Random mem_ready stalls -> results identical to REQ-038; address, to_memory and strobes held stable during every stall cycle.
REQ-042 rst asserted during WRITE of the 2nd output, then a new start -> outputs immediately 0 and idle after reset; the new pass completes normally with correct values.
REQ-043 start pulsed during busy, and out_base near 2^ADDR_W-1 -> second start ignored; output addresses wrap to 0.
